fp32_to_int32_seq: RTL and testbench
====================================

// Module: fp32_to_int32_seq
// PURPOSE
//  Multi-cycle converter from IEEE-754 single precision (the packed format that the
//  FP add/sub datapath produces) to signed 32-bit two's-complement integer.
//  Rounding is truncation toward zero; out-of-range results saturate; status flags are reported.
//  Sits after the FP add/sub unit on the datapath.
//  Uses valid/ready handshakes on both sides.
//  Mantissa alignment is iterative (SHIFT_STEP bit positions per cycle), so no full barrel shifter is needed.
// PARAMETERS
//  SHIFT_STEP  1  bit positions shifted per SHIFT cycle; legal values 1,2,4,8
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  in_valid     in   1   in_f is valid
//  in_ready     out  1   block can accept an input (IDLE only)
//  in_f         in   32  FP32 operand {S, E[7:0], M[22:0]}
//  out_valid    out  1   out_i and flags are valid
//  out_ready    in   1   consumer accepts the result
//  out_i        out  32  signed integer result
//  out_ovf      out  1   result saturated (|x| too large, or +/-Inf)
//  out_nan      out  1   input was NaN
//  out_inexact  out  1   nonzero fraction bits were discarded
// BEHAVIOUR
//  Reset: async, all state cleared, FSM=IDLE.
//   Register values: out_valid=0, out_i=0, flags=0, in_ready=1.
//   Reset mid-operation drops the in-flight conversion; no output for it.
//  FSM states: IDLE -> DECODE -> (SHIFT)* -> NEG -> DONE -> IDLE.
//   Special cases skip SHIFT/NEG: DECODE -> DONE.
//  IDLE:
//   in_ready=1. On in_valid: latch in_f (cycle 0) and go to DECODE.
//  DECODE (cycle 1):
//   Compute e = E-127. mag = {8'b0, 1'b1, M}. Shift count k = |e-23|; direction is left if e>=23.
//   E==255, M!=0 : out_i=0x7FFFFFFF, nan=1.
//   E==255, M==0 : saturate by sign, ovf=1.
//   E==0 (zero/denormal) : out_i=0, inexact=(M!=0).
//   e<0 (E in 1..126) : out_i=0, inexact=1.
//   e>=31 : saturate (S=0 -> 0x7FFFFFFF, S=1 -> 0x80000000), ovf=1.
//    Exception: in_f==0xCF000000 gives exactly 0x80000000 with ovf=0.
//  SHIFT:
//   Each cycle shift mag by min(SHIFT_STEP, remaining k).
//   On right shifts, OR the discarded bits into a sticky bit; inexact = sticky.
//   Takes ceil(k/SHIFT_STEP) cycles; skipped when k==0.
//  NEG (1 cycle):
//   out_i = S ? -mag : mag. mag <= 2^31-1 is guaranteed here.
//   -0 (S=1, result 0) yields 0.
//  DONE:
//   out_valid=1. out_i and flags are registered and held stable until out_ready.
//   On out_valid & out_ready: go to IDLE next cycle, drop out_valid, clear flags.
//   No input is accepted in the same cycle as the output handshake.
//  Latency, accept edge = cycle 0:
//   normal: out_valid at cycle 3 + ceil(k/SHIFT_STEP)
//   special: out_valid at cycle 2
//  Flags are mutually exclusive except inexact, which is only set for finite in-range or underflow inputs.
// TESTING (SHIFT_STEP=1 unless stated)
//  1. 0x40490FDB (pi): out_i=3, inexact=1, out_valid at cycle 25.
//  2. 0xC2F60000 (-123.0): out_i=0xFFFFFF85, inexact=0, out_valid at cycle 20.
//  3. 0x4B800001: out_i=0x01000002 (left shift k=1), out_valid at cycle 4.
//     SHIFT_STEP=8 with 0x3F800000: out_i=1, out_valid at cycle 6.
//  4. Specials, each valid at cycle 2:
//     0x4F000000 -> 0x7FFFFFFF, ovf=1
//     0xCF000000 -> 0x80000000, ovf=0
//     0x7FC00000 -> 0x7FFFFFFF, nan=1
//     0xFF800000 -> 0x80000000, ovf=1
//     0x00000001 -> 0, inexact=1
//     0x80000000 -> 0, no flags
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE.
//     out_valid and out_i stay stable; in_ready=0 throughout; in_valid pulses are ignored.
//  6. Assert rst during SHIFT of test 1.
//     out_valid=0 and in_ready=1 immediately; the next input after release converts correctly.

Source files
------------

// File: rtl/fp32_to_int32_seq_if.sv
// Handshake bundle between the FP add/sub result stream and the FP32 -> INT32
// converter.
//   in_valid/in_ready/in_f : operand side (producer -> converter)
//   out_valid/out_ready    : result side (converter -> consumer)
//   out_i                  : signed 32-bit result
//   out_ovf/out_nan/out_inexact : status flags qualified by out_valid
// master = producer/consumer side, slave = converter side.
interface fp32_to_int32_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_f;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_i;
  logic        out_ovf;
  logic        out_nan;
  logic        out_inexact;

  modport master (
    output in_valid, in_f, out_ready,
    input  in_ready, out_valid, out_i, out_ovf, out_nan, out_inexact
  );

  modport slave (
    input  in_valid, in_f, out_ready,
    output in_ready, out_valid, out_i, out_ovf, out_nan, out_inexact
  );
endinterface

// File: rtl/fp32_to_int32_seq.sv
// Multi-cycle FP32 -> signed INT32 converter, truncating toward zero, with
// saturation and NaN/overflow/inexact status. The mantissa is aligned
// iteratively, SHIFT_STEP bit positions per cycle (legal: 1, 2, 4, 8).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : slave side of fp32_to_int32_seq_if (operand in, result/flags out)
// Sequence: IDLE -> DECODE -> SHIFT* -> NEG -> DONE -> IDLE; special
// operands go DECODE -> DONE directly.
module fp32_to_int32_seq #(
  parameter int SHIFT_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fp32_to_int32_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SHIFT,
    S_NEG,
    S_DONE
  } state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      r_state, w_next;

  logic [31:0] r_f;        // latched operand
  logic [31:0] r_mag;      // working magnitude
  logic [4:0]  r_k;        // remaining shift distance
  logic        r_left;     // shift direction
  logic        r_sticky;   // OR of bits dropped by right shifts
  logic [31:0] r_out_i;
  logic        r_ovf, r_nan, r_inexact;

  // ---------------------------------------------------------------- decode
  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic        w_man_nz;
  logic        w_special;
  logic        w_left;
  logic [4:0]  w_k;

  assign w_sign   = r_f[31];
  assign w_exp    = r_f[30:23];
  assign w_man    = r_f[22:0];
  assign w_man_nz = |w_man;

  // Only exponents 127..157 (e = 0..30) take the shift path; everything
  // else (Inf/NaN, zero/denormal, |x| < 1, |x| >= 2^31) resolves in DECODE.
  assign w_special = (w_exp == 8'hFF) || (w_exp < 8'd127) || (w_exp >= 8'd158);

  // Binary point sits 23 bits up in the mantissa, so e == 23 <=> E == 150.
  assign w_left = (w_exp >= 8'd150);
  assign w_k    = w_left ? 5'(w_exp - 8'd150) : 5'(8'd150 - w_exp);

  logic [31:0] w_sp_i;
  logic        w_sp_ovf, w_sp_nan, w_sp_inex;

  always_comb begin
    w_sp_i    = 32'h0;
    w_sp_ovf  = 1'b0;
    w_sp_nan  = 1'b0;
    w_sp_inex = 1'b0;
    if (w_exp == 8'hFF) begin
      if (w_man_nz) begin
        w_sp_i   = 32'h7FFF_FFFF;
        w_sp_nan = 1'b1;
      end else begin
        w_sp_i   = w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_sp_ovf = 1'b1;
      end
    end else if (w_exp == 8'h00) begin
      w_sp_inex = w_man_nz;
    end else if (w_exp < 8'd127) begin
      w_sp_inex = 1'b1;
    end else begin
      // -2^31 is the one value with e == 31 that is exactly representable.
      if (r_f == 32'hCF00_0000) begin
        w_sp_i = 32'h8000_0000;
      end else begin
        w_sp_i   = w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_sp_ovf = 1'b1;
      end
    end
  end

  // ----------------------------------------------------------------- shift
  logic [4:0]  w_amt;
  logic [31:0] w_mask;
  logic [4:0]  w_k_rem;
  logic        w_lost;
  logic [31:0] w_shifted;

  // Shift amount is at most 8, so this is a small mux, not a barrel shifter.
  assign w_amt     = (r_k < STEP) ? r_k : STEP;
  assign w_mask    = (32'd1 << w_amt) - 32'd1;
  assign w_lost    = |(r_mag & w_mask);
  assign w_k_rem   = r_k - w_amt;
  assign w_shifted = r_left ? (r_mag << w_amt) : (r_mag >> w_amt);

  // ------------------------------------------------------------------ neg
  // mag <= 2^31-1 here, so the negate never overflows.
  logic [31:0] w_signed;
  assign w_signed = w_sign ? (~r_mag + 32'd1) : r_mag;

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.in_valid) w_next = S_DECODE;
      S_DECODE: begin
        if (w_special)      w_next = S_DONE;
        else if (w_k == 0)  w_next = S_NEG;
        else                w_next = S_SHIFT;
      end
      S_SHIFT:  if (w_k_rem == 0) w_next = S_NEG;
      S_NEG:    w_next = S_DONE;
      S_DONE:   if (bus.out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f       <= 32'h0;
      r_mag     <= 32'h0;
      r_k       <= 5'd0;
      r_left    <= 1'b0;
      r_sticky  <= 1'b0;
      r_out_i   <= 32'h0;
      r_ovf     <= 1'b0;
      r_nan     <= 1'b0;
      r_inexact <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) r_f <= bus.in_f;
        end
        S_DECODE: begin
          if (w_special) begin
            r_out_i   <= w_sp_i;
            r_ovf     <= w_sp_ovf;
            r_nan     <= w_sp_nan;
            r_inexact <= w_sp_inex;
          end else begin
            r_mag    <= {8'b0, 1'b1, w_man};
            r_k      <= w_k;
            r_left   <= w_left;
            r_sticky <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_mag <= w_shifted;
          r_k   <= w_k_rem;
          if (!r_left) r_sticky <= r_sticky | w_lost;
        end
        S_NEG: begin
          r_out_i   <= w_signed;
          r_ovf     <= 1'b0;
          r_nan     <= 1'b0;
          r_inexact <= r_sticky;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_ovf     <= 1'b0;
            r_nan     <= 1'b0;
            r_inexact <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.out_i       = r_out_i;
  assign bus.out_ovf     = r_ovf;
  assign bus.out_nan     = r_nan;
  assign bus.out_inexact = r_inexact;

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Bench for fp32_to_int32_seq: one instance with SHIFT_STEP=1, one with
// SHIFT_STEP=8. Expected results go to a per-instance scoreboard queue when
// an operand is driven and are compared when the result handshake happens.
module tb_fp32_to_int32_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp32_to_int32_seq_if b1();
  fp32_to_int32_seq_if b8();

  fp32_to_int32_seq #(.SHIFT_STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  fp32_to_int32_seq #(.SHIFT_STEP(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_OVF  = 3'b100;
  localparam logic [2:0] F_NAN  = 3'b010;
  localparam logic [2:0] F_INX  = 3'b001;

  typedef struct {
    logic [31:0] f;
    logic [31:0] ei;
    logic [2:0]  fl;   // {ovf, nan, inexact}
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] i;
    logic [2:0]  fl;
    string       name;
  } exp_t;

  vec_t vt1[$];
  vec_t vt8[$];
  exp_t sb1[$];
  exp_t sb8[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic [31:0] f, input logic [31:0] ei,
                              input logic [2:0] fl, input int lat, input string name);
    vec_t v;
    v.f = f; v.ei = ei; v.fl = fl; v.lat = lat; v.name = name;
    return v;
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [31:0] f);
    if (sel == 8) begin b8.in_valid = v; b8.in_f = f; end
    else          begin b1.in_valid = v; b1.in_f = f; end
  endtask

  task automatic set_rdy(input int sel, input logic r);
    if (sel == 8) b8.out_ready = r;
    else          b1.out_ready = r;
  endtask

  function automatic logic ovld(input int sel);
    return (sel == 8) ? b8.out_valid : b1.out_valid;
  endfunction

  task automatic cmp(input string dut, input exp_t e, input logic [31:0] ai, input logic [2:0] af);
    n_vec++;
    if (ai !== e.i || af !== e.fl) begin
      n_err++;
      $display("FAIL %s %s: got i=%08h fl=%03b, want i=%08h fl=%03b", dut, e.name, ai, af, e.i, e.fl);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (b1.out_valid && b1.out_ready) begin
        if (sb1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dut1 unexpected output i=%08h, want none", b1.out_i);
        end else begin
          e = sb1.pop_front();
          cmp("dut1", e, b1.out_i, {b1.out_ovf, b1.out_nan, b1.out_inexact});
        end
      end
      if (b8.out_valid && b8.out_ready) begin
        if (sb8.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dut8 unexpected output i=%08h, want none", b8.out_i);
        end else begin
          e = sb8.pop_front();
          cmp("dut8", e, b8.out_i, {b8.out_ovf, b8.out_nan, b8.out_inexact});
        end
      end
    end
  endtask

  // Drive one operand, measure cycles to out_valid (accept edge = cycle 0),
  // then complete the result handshake.
  task automatic apply(input int sel, input vec_t v);
    exp_t e;
    int   cyc;
    e.i = v.ei; e.fl = v.fl; e.name = v.name;
    if (sel == 8) sb8.push_back(e); else sb1.push_back(e);
    drive_in(sel, 1'b1, v.f);
    @(posedge clk); #1;
    drive_in(sel, 1'b0, 32'h0);
    cyc = 1;
    while (!ovld(sel) && cyc < 300) begin
      @(posedge clk); #1; cyc++;
    end
    n_vec++;
    if (!ovld(sel)) begin
      n_err++;
      $display("FAIL %s latency: no out_valid within %0d cycles, want %0d", v.name, cyc, v.lat);
    end else if (cyc != v.lat) begin
      n_err++;
      $display("FAIL %s latency: got cycle %0d, want %0d", v.name, cyc, v.lat);
    end
    set_rdy(sel, 1'b1);
    @(posedge clk); #1;
    set_rdy(sel, 1'b0);
  endtask

  initial begin
    logic [31:0] hold;
    exp_t        e;
    int          cyc;

    vt1.push_back(mk(32'h40490FDB, 32'h0000_0003, F_INX,  25, "pi"));
    vt1.push_back(mk(32'hC2F60000, 32'hFFFF_FF85, F_NONE, 20, "-123"));
    vt1.push_back(mk(32'h4B800001, 32'h0100_0002, F_NONE,  4, "left_k1"));
    vt1.push_back(mk(32'h4F000000, 32'h7FFF_FFFF, F_OVF,   2, "2^31"));
    vt1.push_back(mk(32'hCF000000, 32'h8000_0000, F_NONE,  2, "-2^31"));
    vt1.push_back(mk(32'h7FC00000, 32'h7FFF_FFFF, F_NAN,   2, "qnan"));
    vt1.push_back(mk(32'hFF800000, 32'h8000_0000, F_OVF,   2, "-inf"));
    vt1.push_back(mk(32'h00000001, 32'h0000_0000, F_INX,   2, "denorm_min"));
    vt1.push_back(mk(32'h80000000, 32'h0000_0000, F_NONE,  2, "-zero"));
    vt1.push_back(mk(32'h3F800000, 32'h0000_0001, F_NONE, 26, "1.0"));
    vt1.push_back(mk(32'hBF800000, 32'hFFFF_FFFF, F_NONE, 26, "-1.0"));
    vt1.push_back(mk(32'h3F000000, 32'h0000_0000, F_INX,   2, "0.5"));
    vt1.push_back(mk(32'h3FC00000, 32'h0000_0001, F_INX,  26, "1.5"));
    vt1.push_back(mk(32'hC0490FDB, 32'hFFFF_FFFD, F_INX,  25, "-pi"));
    vt1.push_back(mk(32'h4B000000, 32'h0080_0000, F_NONE,  3, "2^23_k0"));
    vt1.push_back(mk(32'h4EFFFFFF, 32'h7FFF_FF80, F_NONE, 10, "max_pos"));
    vt1.push_back(mk(32'hCEFFFFFF, 32'h8000_0080, F_NONE, 10, "max_neg"));
    vt1.push_back(mk(32'h7F800000, 32'h7FFF_FFFF, F_OVF,   2, "+inf"));
    vt1.push_back(mk(32'hCF000001, 32'h8000_0000, F_OVF,   2, "below_-2^31"));
    vt1.push_back(mk(32'hFFC00000, 32'h7FFF_FFFF, F_NAN,   2, "-qnan"));
    vt1.push_back(mk(32'h80400000, 32'h0000_0000, F_INX,   2, "-denorm"));

    vt8.push_back(mk(32'h3F800000, 32'h0000_0001, F_NONE,  6, "s8_1.0"));
    vt8.push_back(mk(32'h40490FDB, 32'h0000_0003, F_INX,   6, "s8_pi"));
    vt8.push_back(mk(32'hC2F60000, 32'hFFFF_FF85, F_NONE,  6, "s8_-123"));
    vt8.push_back(mk(32'h4B800001, 32'h0100_0002, F_NONE,  4, "s8_left_k1"));
    vt8.push_back(mk(32'h4EFFFFFF, 32'h7FFF_FF80, F_NONE,  4, "s8_max_pos"));

    drive_in(1, 1'b0, 32'h0); drive_in(8, 1'b0, 32'h0);
    set_rdy(1, 1'b0); set_rdy(8, 1'b0);

    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || b1.out_i !== 32'h0 ||
        {b1.out_ovf, b1.out_nan, b1.out_inexact} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b i=%08h fl=%b%b%b, want 1 0 00000000 000",
               b1.in_ready, b1.out_valid, b1.out_i, b1.out_ovf, b1.out_nan, b1.out_inexact);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vt1[i]) apply(1, vt1[i]);
    foreach (vt8[i]) apply(8, vt8[i]);

    // Backpressure: hold result for 5 cycles while poking in_valid.
    e.i = 32'h0000_007B; e.fl = F_NONE; e.name = "bp_123";
    sb1.push_back(e);
    drive_in(1, 1'b1, 32'h42F60000);
    @(posedge clk); #1;
    drive_in(1, 1'b0, 32'h0);
    cyc = 1;
    while (!b1.out_valid && cyc < 300) begin @(posedge clk); #1; cyc++; end
    hold = b1.out_i;
    for (int c = 0; c < 5; c++) begin
      drive_in(1, (c % 2) == 0, 32'h3F800000);
      @(posedge clk); #1;
      n_vec++;
      if (!b1.out_valid || b1.out_i !== hold || b1.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure c%0d: got vld=%b i=%08h rdy=%b, want 1 %08h 0",
                 c, b1.out_valid, b1.out_i, b1.in_ready, hold);
      end
    end
    drive_in(1, 1'b0, 32'h0);
    set_rdy(1, 1'b1);
    @(posedge clk); #1;
    set_rdy(1, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    n_vec++;
    if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ignored_inputs: got vld=%b rdy=%b, want 0 1", b1.out_valid, b1.in_ready);
    end

    // Reset in the middle of a SHIFT sequence.
    drive_in(1, 1'b1, 32'h40490FDB);
    @(posedge clk); #1;
    drive_in(1, 1'b0, 32'h0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_shift_reset: got vld=%b rdy=%b, want 0 1", b1.out_valid, b1.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    apply(1, mk(32'hC2F60000, 32'hFFFF_FF85, F_NONE, 20, "after_reset_-123"));

    repeat (3) @(posedge clk);
    n_vec++;
    if (sb1.size() != 0 || sb8.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", sb1.size(), sb8.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
